// File: rtl/falcon_pkg.sv
// Shared Falcon keygen definitions: default polynomial parameters, the
// mkpoly collector state encoding and the small-coefficient range check.
package falcon_pkg;

  localparam int unsigned FALCON_LOGN   = 9;
  localparam int unsigned FALCON_COEF_W = 8;
  localparam int unsigned FALCON_BOUND  = 127;

  typedef enum logic [0:0] {
    MKPOLY_IDLE    = 1'b0,
    MKPOLY_COLLECT = 1'b1
  } mkpoly_state_e;

  // True when -bound <= val <= bound, compared at full 32-bit signed width.
  function automatic logic is_small(input logic signed [31:0] val,
                                    input logic signed [31:0] bound);
    return (val >= -bound) && (val <= bound);
  endfunction

endpackage

// File: rtl/mkpoly_accept.sv
// Combinational accept decision for one Gaussian sample.
// Ports:
//   val_i      32-bit signed sample
//   last_i     sample targets the final coefficient (parity must become odd)
//   parity_i   running parity of accepted coefficients
//   in_range_c sample lies within +/-BOUND
//   accept_c   sample is accepted
module mkpoly_accept
  import falcon_pkg::*;
#(
  parameter int unsigned BOUND = FALCON_BOUND
) (
  input  logic [31:0] val_i,
  input  logic        last_i,
  input  logic        parity_i,
  output logic        in_range_c,
  output logic        accept_c
);

  assign in_range_c = is_small($signed(val_i), $signed(32'(BOUND)));

  // The last coefficient is only taken if it makes the total parity odd.
  assign accept_c = in_range_c && (!last_i || (parity_i ^ val_i[0]));

endmodule

// File: rtl/mkpoly_collect.sv
// Collects MKGAUSS samples into one small polynomial of N = 2**LOGN
// coefficients, rejecting out-of-range samples and resampling the last
// coefficient until total parity is odd. Accepted coefficients are written
// to an external RAM one cycle after their strobe.
// Optional: define MKPOLY_SQNORM_EN to add the sqnorm output (sum of squares
// of accepted coefficients).
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   start          begin a new polynomial (honoured only when idle)
//   val_valid, val sample stream (no backpressure)
//   coef_we/addr/data  coefficient RAM write port
//   busy, done     collecting / single-cycle completion pulse
//   rej_cnt        saturating rejected-sample count
//   sqnorm         (MKPOLY_SQNORM_EN only) sum of val*val over accepts
module mkpoly_collect
  import falcon_pkg::*;
#(
  parameter int unsigned LOGN   = FALCON_LOGN,
  parameter int unsigned COEF_W = FALCON_COEF_W,
  parameter int unsigned BOUND  = FALCON_BOUND,
  parameter int unsigned REJ_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              val_valid,
  input  logic [31:0]       val,
  output logic              coef_we,
  output logic [LOGN-1:0]   coef_addr,
  output logic [COEF_W-1:0] coef_data,
  output logic              busy,
  output logic              done,
`ifdef MKPOLY_SQNORM_EN
  output logic [31:0]       sqnorm,
`endif
  output logic [REJ_W-1:0]  rej_cnt
);

  localparam int unsigned N = 1 << LOGN;
  localparam logic [0:0] IDLE    = 1'(MKPOLY_IDLE);
  localparam logic [0:0] COLLECT = 1'(MKPOLY_COLLECT);

  logic [0:0]        state_q, state_d;
  logic [LOGN-1:0]   idx_q, idx_d;
  logic              parity_q, parity_d;
  logic              coef_we_q, coef_we_d;
  logic [LOGN-1:0]   coef_addr_q, coef_addr_d;
  logic [COEF_W-1:0] coef_data_q, coef_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [REJ_W-1:0]  rej_cnt_q, rej_cnt_d;

  logic last_c;
  logic in_range_c;
  logic accept_c;

  assign last_c = (idx_q == LOGN'(N - 1));

  mkpoly_accept #(
    .BOUND (BOUND)
  ) u_accept (
    .val_i      (val),
    .last_i     (last_c),
    .parity_i   (parity_q),
    .in_range_c (in_range_c),
    .accept_c   (accept_c)
  );

`ifdef MKPOLY_SQNORM_EN
  logic [31:0] sqnorm_q, sqnorm_d;
  logic signed [COEF_W-1:0]   cv_c;
  logic signed [2*COEF_W-1:0] cv_ext_c;
  logic signed [2*COEF_W-1:0] sq_c;

  // Accepted samples fit in COEF_W signed, so square the truncated value.
  assign cv_c     = $signed(val[COEF_W-1:0]);
  assign cv_ext_c = $signed({{COEF_W{cv_c[COEF_W-1]}}, cv_c});
  assign sq_c     = cv_ext_c * cv_ext_c;
  assign sqnorm   = sqnorm_q;
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      parity_q    <= 1'b0;
      coef_we_q   <= 1'b0;
      coef_addr_q <= '0;
      coef_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rej_cnt_q   <= '0;
`ifdef MKPOLY_SQNORM_EN
      sqnorm_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      parity_q    <= parity_d;
      coef_we_q   <= coef_we_d;
      coef_addr_q <= coef_addr_d;
      coef_data_q <= coef_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rej_cnt_q   <= rej_cnt_d;
`ifdef MKPOLY_SQNORM_EN
      sqnorm_q    <= sqnorm_d;
`endif
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    parity_d    = parity_q;
    coef_we_d   = 1'b0;
    coef_addr_d = coef_addr_q;
    coef_data_d = coef_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rej_cnt_d   = rej_cnt_q;
`ifdef MKPOLY_SQNORM_EN
    sqnorm_d    = sqnorm_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = COLLECT;
          idx_d     = '0;
          parity_d  = 1'b0;
          rej_cnt_d = '0;
          busy_d    = 1'b1;
`ifdef MKPOLY_SQNORM_EN
          sqnorm_d  = '0;
`endif
        end
      end
      COLLECT: begin
        if (val_valid) begin
          if (accept_c) begin
            coef_we_d   = 1'b1;
            coef_addr_d = idx_q;
            coef_data_d = val[COEF_W-1:0];
            parity_d    = parity_q ^ val[0];
            idx_d       = idx_q + LOGN'(1);
`ifdef MKPOLY_SQNORM_EN
            sqnorm_d    = sqnorm_q + 32'($unsigned(sq_c));
`endif
            if (last_c) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else if (rej_cnt_q != {REJ_W{1'b1}}) begin
            rej_cnt_d = rej_cnt_q + REJ_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign coef_we   = coef_we_q;
  assign coef_addr = coef_addr_q;
  assign coef_data = coef_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rej_cnt   = rej_cnt_q;

endmodule
